selector_arbiter: RTL and testbench

Round-robin arbiter that shares one `Selector` mux (and the downstream resource it feeds) between `inputs` requesters. Each requester raises a request line and holds it for as long as it owns the resource. The arbiter drives the mux `Sel` index plus a one-hot grant, and guarantees at least one idle cycle between owners. It sits beside the `Selector2`/`Selector3` instances in the datapath, replacing a fixed or testbench-driven `Sel`.

---
 rtl/selector_arbiter.sv | 144 ++++++++++++++
 tb/tb_selector_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/selector_arbiter.sv
// -----------------------------------------------------------------------------
// selector_arbiter
//   Round-robin arbiter sharing one Selector mux (and the resource behind it)
//   between `inputs` requesters. It drives the mux Sel index and a one-hot
//   Grant, and always leaves one idle cycle between two owners.
//
//   Optional feature macro: SELECTOR_ARB_TIMEOUT_EN
//     defined   : an owner holding for MaxHold GRANT cycles while another
//                 requester waits is preempted (Timeout pulses).
//     undefined : ownership ends only when the owner drops Req; Timeout = 0.
//
// Ports
//   Clk        : clock, rising edge
//   Reset_n    : asynchronous active-low reset
//   Req        : [inputs] level requests, held high while owning
//   Grant      : [inputs] registered one-hot (or zero) current owner
//   Sel        : [SelW]   registered index of current/last owner
//   Busy       : high while in GRANT
//   Timeout    : one-cycle pulse when an owner is preempted
//   dbg_state  : [2] current FSM state, for checkers
//
// Request/grant protocol: Req is a level. A requester raises Req and keeps it
// high for the whole ownership; Grant answers one cycle after arbitration and
// stays until the owner drops Req (or is preempted). Dropping Req before being
// granted withdraws the request; nothing is latched.
// -----------------------------------------------------------------------------
module selector_arbiter #(
  parameter int bits    = 16,
  parameter int inputs  = 4,
  parameter int SelW    = (inputs > 1) ? $clog2(inputs) : 1,
  parameter int MaxHold = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [inputs-1:0] Req,
  output logic [inputs-1:0] Grant,
  output logic [SelW-1:0]   Sel,
  output logic              Busy,
  output logic              Timeout,
  output logic [1:0]        dbg_state
);

  // Elaboration-time guard on the parameter ranges this block supports.
  if (bits < 1 || inputs < 2 || inputs > 16 || MaxHold < 1 || MaxHold > 255)
  begin : g_bad_param
    $error("selector_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [inputs-1:0] ONE      = {{(inputs-1){1'b0}}, 1'b1};
  localparam logic [SelW-1:0]   LAST_IDX = SelW'(inputs - 1);

  state_t          state;
  logic [SelW-1:0] last;

  // Round-robin scan: walk from last+1 with explicit wrap at inputs-1, so
  // indices >= inputs are never formed even when inputs is not a power of 2.
  logic [SelW-1:0] scan;
  logic [SelW-1:0] win_idx;
  logic            win_found;

  always_comb begin
    scan      = last;
    win_idx   = last;
    win_found = 1'b0;
    for (int i = 0; i < inputs; i++) begin
      scan = (scan == LAST_IDX) ? '0 : scan + 1'b1;
      if (!win_found && Req[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
    end
  end

`ifdef SELECTOR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic [7:0] hold_next;
  logic       others_waiting;

  // Counter saturates so an uncontested owner can hold forever.
  assign hold_next      = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
  assign others_waiting = (Req & ~Grant) != '0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      Grant    <= '0;
      Sel      <= '0;
      last     <= LAST_IDX;
      Timeout  <= 1'b0;
`ifdef SELECTOR_ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      Timeout <= 1'b0;
      case (state)
        IDLE, RELEASE: begin
          if (win_found) begin
            state    <= GRANT;
            Grant    <= ONE << win_idx;
            Sel      <= win_idx;
`ifdef SELECTOR_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // A voluntary release wins over a coincident timeout: no pulse.
          if (!Req[Sel]) begin
            state <= RELEASE;
            Grant <= '0;
            last  <= Sel;
          end
`ifdef SELECTOR_ARB_TIMEOUT_EN
          else if (hold_next >= 8'(MaxHold) && others_waiting) begin
            state   <= RELEASE;
            Grant   <= '0;
            last    <= Sel;
            Timeout <= 1'b1;
          end else begin
            hold_cnt <= hold_next;
          end
`endif
        end
        default: begin
          state <= IDLE;
          Grant <= '0;
        end
      endcase
    end
  end

  assign Busy      = (state == GRANT);
  assign dbg_state = state;

endmodule

// File: tb/tb_selector_arbiter.sv
// -----------------------------------------------------------------------------
// tb_selector_arbiter
//   Self-checking bench for selector_arbiter (inputs = 4, MaxHold = 8).
//   Directed scenarios followed by randomized requests, all compared each
//   cycle against a behavioural owner/last-pointer model.
// -----------------------------------------------------------------------------
module tb_selector_arbiter;

  localparam int N        = 4;
  localparam int SW       = 2;
  localparam int MAX_HOLD = 8;

  // ---------------- clock / reset ----------------
  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [N-1:0]  Req;
  logic [N-1:0]  Grant;
  logic [SW-1:0] Sel;
  logic          Busy;
  logic          Timeout;
  logic [1:0]    dbg_state;

  always #5 Clk = ~Clk;

  selector_arbiter #(
    .bits    (16),
    .inputs  (N),
    .SelW    (SW),
    .MaxHold (MAX_HOLD)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Req       (Req),
    .Grant     (Grant),
    .Sel       (Sel),
    .Busy      (Busy),
    .Timeout   (Timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Owner is a requester index or -1; the mandatory gap falls out naturally
  // because a freed slot only arbitrates on the following edge.
  int m_owner;
  int m_last;
  int m_sel;
  int m_hold;
  int m_to;

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_sel   = 0;
    m_hold  = 0;
    m_to    = 0;
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int j = 1; j <= N; j++) begin
      int k;
      k = (m_last + j) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r);
    int w;
    m_to = 0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end
`ifdef SELECTOR_ARB_TIMEOUT_EN
      else begin
        logic [N-1:0] others;
        m_hold = (m_hold < 255) ? m_hold + 1 : 255;
        others = r;
        others[m_owner] = 1'b0;
        if (m_hold >= MAX_HOLD && others != '0) begin
          m_last  = m_owner;
          m_owner = -1;
          m_to    = 1;
        end
      end
`endif
    end else begin
      w = pick(r);
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_hold  = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".grant"},   int'(Grant),   (m_owner >= 0) ? (1 << m_owner) : 0);
    check({tag, ".sel"},     int'(Sel),     m_sel);
    check({tag, ".busy"},    int'(Busy),    (m_owner >= 0) ? 1 : 0);
    check({tag, ".timeout"}, int'(Timeout), m_to);
  endtask

  // ---------------- driver tasks ----------------
  // Drive Req mid-cycle, step model on the edge, sample 1 ns after it.
  task automatic tick(input logic [N-1:0] r, input string tag);
    Req = r;
    @(posedge Clk);
    model_step(r);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // ---------------- scoreboard for grant order ----------------
  logic [SW-1:0] exp_q[$];

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] r;
    logic [N-1:0] prev_grant;
    int own_cnt;

    Reset_n = 1'b0;
    Req     = '0;
    model_reset();
    #2;
    check_outputs("reset0");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Single request: grant one cycle later, released one cycle after drop.
    tick(4'b0000, "idle");
    tick(4'b0100, "single");
    check("single_grant", int'(Grant), 4);
    check("single_sel", int'(Sel), 2);
    tick(4'b0100, "single_hold");
    tick(4'b0000, "single_drop");
    check("single_drop_grant", int'(Grant), 0);
    check("single_drop_sel", int'(Sel), 2);
    tick(4'b0000, "idle2");

    // All four requesting, each owner drops after 3 GRANT cycles.
    do_reset("reset1");
    exp_q      = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    prev_grant = '0;
    own_cnt    = 0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      r = 4'b1111;
      if (m_owner >= 0 && own_cnt >= 3) r[m_owner] = 1'b0;
      tick(r, "rr");
      if (m_owner >= 0) own_cnt++;
      else own_cnt = 0;
      if (Grant != '0 && prev_grant == '0) begin
        logic [SW-1:0] e;
        e = exp_q.pop_front();
        check("rr_order", int'(Sel), int'(e));
      end
      prev_grant = Grant;
    end
    check("rr_order_done", exp_q.size(), 0);

    // Wrap-around: owner 3 then 4'b1001 -> 0 first, then 3.
    tick(4'b0000, "wrap_clr");
    tick(4'b0000, "wrap_clr2");
    tick(4'b1000, "wrap_g3");
    tick(4'b0000, "wrap_d3");
    tick(4'b1001, "wrap_g0");
    check("wrap_first", int'(Sel), 0);
    tick(4'b1001, "wrap_h0");
    tick(4'b1000, "wrap_d0");
    tick(4'b1000, "wrap_g3b");
    check("wrap_second", int'(Sel), 3);
    tick(4'b0000, "wrap_end");
    tick(4'b0000, "wrap_idle");

    // Non-owner noise on Req[2] while requester 1 holds.
    tick(4'b0010, "noise_g1");
    for (int c = 0; c < 10; c++) begin
      tick((c % 2 == 0) ? 4'b0110 : 4'b0010, "noise");
      check("noise_grant", int'(Grant), 2);
    end
    tick(4'b0000, "noise_drop");
    tick(4'b0000, "noise_idle");

    // Requester 0 holds forever, requester 3 joins: preempted only with
    // the timeout feature built in.
    tick(4'b0001, "to_g0");
    tick(4'b0001, "to_h0");
    for (int c = 0; c < 16; c++) tick(4'b1001, "to");
    tick(4'b0000, "to_drop");
    tick(4'b0000, "to_idle");

    // Reset in the middle of a grant.
    tick(4'b0010, "mid_g1");
    tick(4'b0010, "mid_h1");
    check("mid_pre_grant", int'(Grant), 2);
    do_reset("mid_reset");
    check("mid_reset_grant", int'(Grant), 0);
    tick(4'b0011, "mid_after");
    check("mid_after_sel", int'(Sel), 0);
    tick(4'b0000, "mid_drop");

    // Randomized requests; current owner is biased to keep holding.
    for (int c = 0; c < 400; c++) begin
      r = N'($urandom_range(0, (1 << N) - 1));
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
      if ($urandom_range(0, 9) == 0) r = '0;
      tick(r, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
